// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcodes,
// ALU operator codes, write-back selects and FSM/decode encodings.
package instr_sequencer_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int ALU_OPW = 3;
  localparam int PC_W    = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_MULT = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_LWI  = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_MOD  = 4'hA;
  localparam logic [3:0] OP_ROTL = 4'hB;
  localparam logic [3:0] OP_BLE  = 4'hC;
  localparam logic [3:0] OP_BGE  = 4'hD;
  localparam logic [3:0] OP_BEQ  = 4'hE;
  localparam logic [3:0] OP_J    = 4'hF;

  localparam logic [ALU_OPW-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_OPW-1:0] ALU_MULT = 3'd2;
  localparam logic [ALU_OPW-1:0] ALU_NAND = 3'd3;
  localparam logic [ALU_OPW-1:0] ALU_DIV  = 3'd4;
  localparam logic [ALU_OPW-1:0] ALU_MOD  = 3'd5;
  localparam logic [ALU_OPW-1:0] ALU_ROTL = 3'd6;
  localparam logic [ALU_OPW-1:0] ALU_NOP  = 3'd7;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMEM = 2'd1;
  localparam logic [1:0] WB_IMM  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_BRANCH = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_MEM    = 3'd1,
    CL_LWI    = 3'd2,
    CL_BRANCH = 3'd3,
    CL_JUMP   = 3'd4
  } instr_class_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the sequencer and the fetch port, register file,
// ALU and data memory. The sequencer side is the master.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [REG_AW-1:0] reg_addr_a;
  logic [REG_AW-1:0] reg_addr_b;
  logic [REG_AW-1:0] reg_addr_c;
  logic              reg_we;
  logic [DATA_W-1:0] reg_rdata_a;
  logic [DATA_W-1:0] reg_rdata_b;
  logic [1:0]        wb_sel;
  logic [DATA_W-1:0] imm;
  logic [ALU_OPW-1:0] alu_operator;
  logic              alu_src_imm;
  logic              alu_start;
  logic              alu_done;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic [PC_W-1:0]   pc;

  modport master (
    output imem_req, imem_addr, reg_addr_a, reg_addr_b, reg_addr_c, reg_we,
           wb_sel, imm, alu_operator, alu_src_imm, alu_start, dmem_req,
           dmem_we, pc,
    input  imem_ack, imem_rdata, reg_rdata_a, reg_rdata_b, alu_done, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, reg_addr_a, reg_addr_b, reg_addr_c, reg_we,
           wb_sel, imm, alu_operator, alu_src_imm, alu_start, dmem_req,
           dmem_we, pc,
    output imem_ack, imem_rdata, reg_rdata_a, reg_rdata_b, alu_done, dmem_ack
  );

endinterface

// File: rtl/instr_sequencer_decode.sv
// Combinational decode of the instruction register into its class and the
// control values the sequencer latches during DECODE.
module instr_sequencer_decode
  import instr_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0]  ir,
  output instr_class_t       dec_class,
  output logic [ALU_OPW-1:0] dec_alu_op,
  output logic [REG_AW-1:0]  dec_addr_a,
  output logic [REG_AW-1:0]  dec_addr_b,
  output logic [REG_AW-1:0]  dec_addr_c,
  output logic [DATA_W-1:0]  dec_imm,
  output logic [1:0]         dec_wb_sel,
  output logic               dec_src_imm,
  output logic               dec_dmem_we
);

  logic [3:0] op, rc, ra, rb;

  assign op = ir[15:12];
  assign rc = ir[11:8];
  assign ra = ir[7:4];
  assign rb = ir[3:0];

  // Opcode to ALU function; anything that does not use the ALU gets NOP.
  always_comb begin
    dec_alu_op = ALU_NOP;
    case (op)
      OP_ADD, OP_ADDI: dec_alu_op = ALU_ADD;
      OP_SUB, OP_SUBI: dec_alu_op = ALU_SUB;
      OP_MULT:         dec_alu_op = ALU_MULT;
      OP_NAND:         dec_alu_op = ALU_NAND;
      OP_DIV:          dec_alu_op = ALU_DIV;
      OP_MOD:          dec_alu_op = ALU_MOD;
      OP_ROTL:         dec_alu_op = ALU_ROTL;
      default:         dec_alu_op = ALU_NOP;
    endcase
  end

  // Instruction class, register addresses, immediate and write-back source.
  always_comb begin
    dec_class   = CL_ALU;
    dec_addr_a  = '0;
    dec_addr_b  = '0;
    dec_addr_c  = '0;
    dec_imm     = '0;
    dec_wb_sel  = WB_ALU;
    dec_src_imm = 1'b0;
    dec_dmem_we = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MULT, OP_NAND, OP_DIV, OP_MOD, OP_ROTL: begin
        dec_addr_a = ra;
        dec_addr_b = rb;
        dec_addr_c = rc;
      end
      OP_ADDI, OP_SUBI: begin
        dec_addr_a  = rc;
        dec_addr_c  = rc;
        dec_src_imm = 1'b1;
        dec_imm     = {{(DATA_W-8){ir[7]}}, ir[7:0]};
      end
      OP_LWI: begin
        dec_class  = CL_LWI;
        dec_addr_c = rc;
        dec_imm    = {{(DATA_W-8){1'b0}}, ir[7:0]};
        dec_wb_sel = WB_IMM;
      end
      OP_LW: begin
        dec_class  = CL_MEM;
        dec_addr_a = ra;
        dec_addr_c = rc;
        dec_wb_sel = WB_DMEM;
      end
      OP_SW: begin
        // ra supplies the store data, rb the address.
        dec_class   = CL_MEM;
        dec_addr_a  = ra;
        dec_addr_b  = rb;
        dec_dmem_we = 1'b1;
      end
      OP_BLE, OP_BGE, OP_BEQ: begin
        dec_class  = CL_BRANCH;
        dec_addr_a = rc;
        dec_addr_b = ra;
        dec_imm    = {{(DATA_W-4){ir[3]}}, ir[3:0]};
      end
      OP_J: begin
        dec_class = CL_JUMP;
        dec_imm   = {{(DATA_W-12){1'b0}}, ir[11:0]};
      end
      default: dec_class = CL_ALU;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute control loop. Owns the program counter,
// the fetch and data-memory handshakes and the ALU start pulse.
//
//   state  | meaning
//   FETCH  | imem_req high until imem_ack, instruction latched into ir
//   DECODE | latch addresses/operator/imm from ir, pick next phase
//   EXEC   | alu_start on first cycle, wait for alu_done
//   MEM    | dmem_req high until dmem_ack
//   BRANCH | signed compare of the two read ports, resolve pc
//   WB     | one-cycle reg_we, pc + 1
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.master  bus
);

  state_t             state;
  logic [DATA_W-1:0]  ir;
  logic [PC_W-1:0]    pc, pc_inc;
  logic               imem_req, dmem_req, dmem_we, reg_we, alu_start, src_imm;
  logic [REG_AW-1:0]  addr_a, addr_b, addr_c;
  logic [DATA_W-1:0]  imm_q;
  logic [1:0]         wb_sel;
  logic [ALU_OPW-1:0] alu_op;

  instr_class_t       dec_class;
  logic [ALU_OPW-1:0] dec_alu_op;
  logic [REG_AW-1:0]  dec_addr_a, dec_addr_b, dec_addr_c;
  logic [DATA_W-1:0]  dec_imm;
  logic [1:0]         dec_wb_sel;
  logic               dec_src_imm, dec_dmem_we;

  logic signed [DATA_W-1:0] opnd_a, opnd_b;
  logic                     taken;

  instr_sequencer_decode u_decode (
    .ir          (ir),
    .dec_class   (dec_class),
    .dec_alu_op  (dec_alu_op),
    .dec_addr_a  (dec_addr_a),
    .dec_addr_b  (dec_addr_b),
    .dec_addr_c  (dec_addr_c),
    .dec_imm     (dec_imm),
    .dec_wb_sel  (dec_wb_sel),
    .dec_src_imm (dec_src_imm),
    .dec_dmem_we (dec_dmem_we)
  );

  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign opnd_a = bus.reg_rdata_a;
  assign opnd_b = bus.reg_rdata_b;

  // Branch condition from the opcode still held in ir.
  always_comb begin
    taken = 1'b0;
    case (ir[15:12])
      OP_BLE:  taken = (opnd_a <= opnd_b);
      OP_BGE:  taken = (opnd_a >= opnd_b);
      OP_BEQ:  taken = (opnd_a == opnd_b);
      default: taken = 1'b0;
    endcase
  end

  // Sequencer FSM with registered strobes; every path back to FETCH raises imem_req.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      reg_we    <= 1'b0;
      alu_start <= 1'b0;
      src_imm   <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_c    <= '0;
      imm_q     <= '0;
      wb_sel    <= WB_ALU;
      alu_op    <= ALU_NOP;
    end else begin
      reg_we    <= 1'b0;
      alu_start <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (bus.imem_ack) begin
            ir       <= bus.imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          addr_a  <= dec_addr_a;
          addr_b  <= dec_addr_b;
          addr_c  <= dec_addr_c;
          imm_q   <= dec_imm;
          wb_sel  <= dec_wb_sel;
          alu_op  <= dec_alu_op;
          src_imm <= dec_src_imm;
          dmem_we <= dec_dmem_we;
          case (dec_class)
            CL_ALU: begin
              alu_start <= 1'b1;
              state     <= ST_EXEC;
            end
            CL_MEM: begin
              dmem_req <= 1'b1;
              state    <= ST_MEM;
            end
            CL_LWI: begin
              reg_we <= 1'b1;
              state  <= ST_WB;
            end
            CL_BRANCH: state <= ST_BRANCH;
            default: begin
              pc       <= PC_W'(dec_imm);
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          endcase
        end
        ST_EXEC: begin
          if (bus.alu_done) begin
            reg_we <= 1'b1;
            state  <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_req && bus.dmem_ack) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              pc       <= pc_inc;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              reg_we <= 1'b1;
              state  <= ST_WB;
            end
          end
        end
        ST_BRANCH: begin
          pc       <= taken ? (pc_inc + PC_W'(imm_q)) : pc_inc;
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_WB: begin
          pc       <= pc_inc;
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = pc;
  assign bus.pc           = pc;
  assign bus.reg_addr_a   = addr_a;
  assign bus.reg_addr_b   = addr_b;
  assign bus.reg_addr_c   = addr_c;
  assign bus.reg_we       = reg_we;
  assign bus.wb_sel       = wb_sel;
  assign bus.imm          = imm_q;
  assign bus.alu_operator = alu_op;
  assign bus.alu_src_imm  = src_imm;
  assign bus.alu_start    = alu_start;
  assign bus.dmem_req     = dmem_req;
  assign bus.dmem_we      = dmem_we;

endmodule
